rbus_pkt_tx: RTL and testbench
==============================

// Module: rbus_pkt_tx
// PURPOSE
//  Source endpoint of the rbus: accepts packets from a local producer, buffers them per priority,
//  and emits them onto an rbus link (stb/sof/data) only when downstream rdy/rdyE grants space.
//  Drives one input of an N-to-M rbus switch; the counterpart of the switch's output-side sinks.
// PARAMETERS
//  DEPTH     16  words per priority FIFO (power of 2, >= LONG_LEN+1)
//  LONG_LEN   8  payload words following the header of a long packet
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset, synchronous, active-low
//  l_stb    in   1   local word valid
//  l_sof    in   1   local word is packet header
//  l_data   in  72   local word; header: [71]=priority, [70]=long flag
//  l_rdy    out  2   l_rdy[p]=1: FIFO p has >= LONG_LEN+1 free words
//  o_stb    out  1   rbus word valid
//  o_sof    out  1   rbus header marker
//  o_data   out 72   rbus word
//  o_rdy    in   2   downstream accepts a long packet of priority p
//  o_rdyE   in   2   downstream accepts a header-only packet of priority p
//  ff_err   out  1   sticky protocol/overflow error
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): o_stb=0, o_sof=0, o_data=0, ff_err=0, FIFOs empty, l_rdy=2'b11, FSM IDLE.
//  - Packet: header (sof=1) plus LONG_LEN payload words if [70]=1, else header only.
//  - Ingress: header selects FIFO by [71]; following words go to same FIFO; word counter tracks remaining.
//    Producer starts a packet only when l_rdy[pri]=1; all words of a packet on consecutive or gapped stb.
//  - Ingress errors set ff_err, word dropped: write to full FIFO; non-sof word when no packet open;
//    sof while packet open (open packet abandoned: FIFO write pointer rolls back to its header).
//  - Per FIFO pkt_cnt = complete packets stored; incremented on write of last word, decremented on
//    read of header. Simultaneous inc/dec leaves count unchanged.
//  - FSM IDLE: pick p=1 if pkt_cnt[1]>0 and grant[1], else p=0 if pkt_cnt[0]>0 and grant[0];
//    grant[p] = head long ? o_rdy[p] : o_rdyE[p]; head long flag read from FIFO head (first-word-fall-through).
//  - SEND: one word per cycle, no stall; o_sof=1 on header only; remaining counter down to 0 -> GAP.
//  - GAP: one cycle, o_stb=0, then IDLE (lets downstream rdy update). o_rdy/o_rdyE ignored outside IDLE.
//  - Outputs registered; o_data holds last value when o_stb=0. Min latency l_stb(last word) -> o_stb = 2 clk.
//  - Pointers wrap modulo DEPTH; full/empty via extra pointer MSB. l_rdy registered from free count.
//  - Reset mid-packet: output truncated immediately (o_stb=0 next edge); buffered data discarded.
//  - ff_err clears only on reset.
// CONFIGURATION
//  RBUS_TX_STATS_EN defined: adds outputs st_pkts[31:0] (packets sent, wraps) and st_drops[15:0]
//  (words dropped, saturating); both reset to 0. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  rbus_pkg: header bit positions (HDR_PRI=71, HDR_LONG=70), word width 72, FSM state enum.
//  Sub-module rbus_tx_fifo: sync FWFT FIFO with pkt_cnt and rollback; instantiated once per priority.
// TESTING
//  1 short pri0 packet, o_rdyE=2'b01 -> one word, o_sof=1, o_stb 1 cycle, 2 clk after l_stb.
//  2 long pri1 packet, o_rdy=2'b10 -> 9 consecutive o_stb, sof only on first, then 1 idle cycle.
//  3 pri0 and pri1 both queued, all rdy=1 -> pri1 packet sent first, pri0 after GAP.
//  4 long pri0 queued, o_rdy=0 o_rdyE=1 -> nothing sent; raise o_rdy[0] -> packet sent.
//  5 payload word with no open packet, or 17th word into full FIFO -> ff_err=1, word absent on bus.
//  6 rst=0 during word 4 of long packet -> next edge o_stb=0, ff_err=0, l_rdy=2'b11.

Source files
------------

// File: rtl/rbus_pkg.sv
// Shared rbus definitions: word width, header bit positions and transmit FSM states.
package rbus_pkg;
  localparam int WORD_W   = 72;
  localparam int HDR_PRI  = 71;
  localparam int HDR_LONG = 70;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;
endpackage

// File: rtl/rbus_tx_fifo.sv
// Synchronous first-word-fall-through packet FIFO with complete-packet count and
// write-pointer rollback to the header of an abandoned packet.
module rbus_tx_fifo
  import rbus_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int LONG_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sof,
  input  logic              wr_last,
  input  logic              rollback,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_hdr,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              pkt_avail,
  output logic              room_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ROOM_V  = (AW+1)'(LONG_LEN + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, hdr_ptr_q, hdr_ptr_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d, used_d;
  logic        room_q, room_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    hdr_ptr_d = hdr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (rollback)   wr_ptr_d = hdr_ptr_q;
    else if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (wr_en && wr_sof) hdr_ptr_d = wr_ptr_q;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en && wr_last, rd_en && rd_hdr})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    // l_rdy reflects the occupancy that will exist after this edge
    used_d = wr_ptr_d - rd_ptr_d;
    room_d = (DEPTH_V - used_d) >= ROOM_V;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      hdr_ptr_q <= '0;
      pkt_cnt_q <= '0;
      room_q    <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      hdr_ptr_q <= hdr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      room_q    <= room_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data   = mem[rd_ptr_q[AW-1:0]];
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pkt_avail = (pkt_cnt_q != '0);
  assign room_ok   = room_q;
endmodule

// File: rtl/rbus_pkt_tx.sv
// rbus source endpoint: per-priority packet buffering and grant-gated link transmit.
// Optional statistics counters enabled by defining RBUS_TX_STATS_EN.
module rbus_pkt_tx
  import rbus_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int LONG_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l_stb,
  input  logic              l_sof,
  input  logic [WORD_W-1:0] l_data,
  output logic [1:0]        l_rdy,
  output logic              o_stb,
  output logic              o_sof,
  output logic [WORD_W-1:0] o_data,
  input  logic [1:0]        o_rdy,
  input  logic [1:0]        o_rdyE,
`ifdef RBUS_TX_STATS_EN
  output logic [31:0]       st_pkts,
  output logic [15:0]       st_drops,
`endif
  output logic              ff_err
);
  localparam int CW = $clog2(LONG_LEN + 1);

  logic [1:0]        wr_en, rollback, rd_en, full, pkt_avail, cand;
  logic              wr_sof, wr_last, rd_hdr, err, hp, pick;
  logic [WORD_W-1:0] rd_data [2];

  logic              open_q, open_d, pri_q, pri_d, sel_q, sel_d, ff_err_q, ff_err_d;
  logic [CW-1:0]     rem_q, rem_d, orem_q, orem_d;
  tx_state_e         state_q, state_d;
  logic              o_stb_q, o_stb_d, o_sof_q, o_sof_d;
  logic [WORD_W-1:0] o_data_q, o_data_d;

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    rbus_tx_fifo #(.DEPTH(DEPTH), .LONG_LEN(LONG_LEN)) u_fifo (
      .clk(clk), .rst(rst),
      .wr_en(wr_en[p]), .wr_sof(wr_sof), .wr_last(wr_last), .rollback(rollback[p]),
      .wr_data(l_data), .rd_en(rd_en[p]), .rd_hdr(rd_hdr), .rd_data(rd_data[p]),
      .full(full[p]), .pkt_avail(pkt_avail[p]), .room_ok(l_rdy[p])
    );
  end

  // Ingress: steer words to the header's FIFO; on any fault the word is dropped and,
  // if a packet is open, it is abandoned so a short packet never reaches the bus.
  always_comb begin
    wr_en    = '0;
    rollback = '0;
    wr_sof   = 1'b0;
    wr_last  = 1'b0;
    err      = 1'b0;
    open_d   = open_q;
    pri_d    = pri_q;
    rem_d    = rem_q;
    hp       = l_data[HDR_PRI];
    if (l_stb) begin
      if (l_sof) begin
        if (open_q) begin
          err             = 1'b1;
          rollback[pri_q] = 1'b1;
          open_d          = 1'b0;
        end else if (full[hp]) begin
          err = 1'b1;
        end else begin
          wr_en[hp] = 1'b1;
          wr_sof    = 1'b1;
          wr_last   = !l_data[HDR_LONG];
          if (l_data[HDR_LONG]) begin
            open_d = 1'b1;
            pri_d  = hp;
            rem_d  = CW'(LONG_LEN);
          end
        end
      end else if (!open_q) begin
        err = 1'b1;
      end else if (full[pri_q]) begin
        err             = 1'b1;
        rollback[pri_q] = 1'b1;
        open_d          = 1'b0;
      end else begin
        wr_en[pri_q] = 1'b1;
        wr_last      = (rem_q == CW'(1));
        rem_d        = rem_q - 1'b1;
        if (rem_q == CW'(1)) open_d = 1'b0;
      end
    end
    ff_err_d = ff_err_q | err;
  end

  always_comb begin
    for (int p = 0; p < 2; p++)
      cand[p] = pkt_avail[p] && (rd_data[p][HDR_LONG] ? o_rdy[p] : o_rdyE[p]);
    pick     = cand[1];
    state_d  = state_q;
    sel_d    = sel_q;
    orem_d   = orem_q;
    rd_en    = '0;
    rd_hdr   = 1'b0;
    o_stb_d  = 1'b0;
    o_sof_d  = 1'b0;
    o_data_d = o_data_q;
    case (state_q)
      ST_IDLE: if (|cand) begin
        rd_en[pick] = 1'b1;
        rd_hdr      = 1'b1;
        o_stb_d     = 1'b1;
        o_sof_d     = 1'b1;
        o_data_d    = rd_data[pick];
        sel_d       = pick;
        orem_d      = CW'(LONG_LEN);
        state_d     = rd_data[pick][HDR_LONG] ? ST_SEND : ST_GAP;
      end
      ST_SEND: begin
        rd_en[sel_q] = 1'b1;
        o_stb_d      = 1'b1;
        o_data_d     = rd_data[sel_q];
        orem_d       = orem_q - 1'b1;
        if (orem_q == CW'(1)) state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      open_q   <= 1'b0;
      pri_q    <= 1'b0;
      rem_q    <= '0;
      sel_q    <= 1'b0;
      orem_q   <= '0;
      state_q  <= ST_IDLE;
      ff_err_q <= 1'b0;
      o_stb_q  <= 1'b0;
      o_sof_q  <= 1'b0;
      o_data_q <= '0;
    end else begin
      open_q   <= open_d;
      pri_q    <= pri_d;
      rem_q    <= rem_d;
      sel_q    <= sel_d;
      orem_q   <= orem_d;
      state_q  <= state_d;
      ff_err_q <= ff_err_d;
      o_stb_q  <= o_stb_d;
      o_sof_q  <= o_sof_d;
      o_data_q <= o_data_d;
    end
  end

`ifdef RBUS_TX_STATS_EN
  logic [31:0] st_pkts_q;
  logic [15:0] st_drops_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_pkts_q  <= '0;
      st_drops_q <= '0;
    end else begin
      if (rd_hdr) st_pkts_q <= st_pkts_q + 1'b1;
      if (err && (st_drops_q != 16'hFFFF)) st_drops_q <= st_drops_q + 1'b1;
    end
  end
  assign st_pkts  = st_pkts_q;
  assign st_drops = st_drops_q;
`endif

  assign o_stb  = o_stb_q;
  assign o_sof  = o_sof_q;
  assign o_data = o_data_q;
  assign ff_err = ff_err_q;
endmodule

// File: tb/tb_rbus_pkt_tx.sv
// Directed bench for rbus_pkt_tx: hand-computed packets, priorities, grants, errors, reset.
module tb_rbus_pkt_tx;
  import rbus_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              l_stb = 1'b0, l_sof = 1'b0;
  logic [WORD_W-1:0] l_data = '0;
  logic [1:0]        l_rdy, o_rdy = 2'b00, o_rdyE = 2'b00;
  logic              o_stb, o_sof, ff_err;
  logic [WORD_W-1:0] o_data;
`ifdef RBUS_TX_STATS_EN
  logic [31:0]       st_pkts;
  logic [15:0]       st_drops;
`endif

  rbus_pkt_tx #(.DEPTH(16), .LONG_LEN(8)) dut (
    .clk(clk), .rst(rst), .l_stb(l_stb), .l_sof(l_sof), .l_data(l_data), .l_rdy(l_rdy),
    .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data), .o_rdy(o_rdy), .o_rdyE(o_rdyE),
`ifdef RBUS_TX_STATS_EN
    .st_pkts(st_pkts), .st_drops(st_drops),
`endif
    .ff_err(ff_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: every valid rbus word with the edge number that launched it
  int                q_cyc [$];
  logic              q_sof [$];
  logic [WORD_W-1:0] q_dat [$];
  always @(posedge clk) begin
    #1;
    if (o_stb) begin
      q_cyc.push_back(cyc);
      q_sof.push_back(o_sof);
      q_dat.push_back(o_data);
    end
  end

  int n_vec = 0, n_miss = 0;
  int wcyc;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_q();
    q_cyc.delete(); q_sof.delete(); q_dat.delete();
  endtask

  function automatic logic [71:0] hdr(input logic pri, input logic lng, input logic [7:0] tag);
    return {pri, lng, 62'd0, tag};
  endfunction

  function automatic logic [71:0] pay(input logic [7:0] tag, input int i);
    return {56'hA5A5_0000_0000_00, tag, 8'(i)};
  endfunction

  // One word, sampled at the next edge; wcyc records that edge
  task automatic send(input logic sof, input logic [71:0] d);
    l_stb = 1'b1; l_sof = sof; l_data = d;
    tick(1);
    wcyc = cyc;
    l_stb = 1'b0; l_sof = 1'b0;
  endtask

  task automatic send_long(input logic pri, input logic [7:0] tag, input int npay);
    send(1'b1, hdr(pri, 1'b1, tag));
    for (int i = 0; i < npay; i++) send(1'b0, pay(tag, i));
  endtask

  task automatic chk_long(input string tag, input int base, input logic pri, input logic [7:0] t);
    chk({tag, "_n"}, 72'(q_dat.size() >= base + 9), 72'd1);
    if (q_dat.size() >= base + 9) begin
      chk({tag, "_hdr"}, q_dat[base], hdr(pri, 1'b1, t));
      for (int i = 0; i < 9; i++) begin
        chk({tag, "_sof"}, 72'(q_sof[base+i]), 72'(i == 0));
        chk({tag, "_seq"}, 72'(q_cyc[base+i] - q_cyc[base]), 72'(i));
        if (i > 0) chk({tag, "_pay"}, q_dat[base+i], pay(t, i-1));
      end
    end
  endtask

  initial begin
    tick(3);
    chk("rst_stb", 72'(o_stb), 72'd0);
    chk("rst_sof", 72'(o_sof), 72'd0);
    chk("rst_data", o_data, 72'd0);
    chk("rst_err", 72'(ff_err), 72'd0);
    chk("rst_lrdy", 72'(l_rdy), 72'd3);
    rst = 1'b1;
    tick(2);

    // 1: short pri0 packet; l_stb in cycle n, o_stb in cycle n+2 (launched one edge later)
    o_rdyE = 2'b01; o_rdy = 2'b00;
    clr_q();
    send(1'b1, hdr(1'b0, 1'b0, 8'h11));
    tick(8);
    chk("t1_cnt", 72'(q_dat.size()), 72'd1);
    if (q_dat.size() > 0) begin
      chk("t1_data", q_dat[0], hdr(1'b0, 1'b0, 8'h11));
      chk("t1_sof", 72'(q_sof[0]), 72'd1);
      chk("t1_lat", 72'(q_cyc[0] - wcyc), 72'd1);
    end
    chk("t1_hold", o_data, hdr(1'b0, 1'b0, 8'h11));

    // 2: long pri1 packet streams as 9 consecutive words
    o_rdy = 2'b10; o_rdyE = 2'b00;
    clr_q();
    send_long(1'b1, 8'h22, 8);
    tick(14);
    chk("t2_cnt", 72'(q_dat.size()), 72'd9);
    chk_long("t2", 0, 1'b1, 8'h22);
    chk("t2_lrdy", 72'(l_rdy), 72'd3);

    // 3: both priorities queued; pri1 wins, pri0 follows after one idle cycle
    o_rdy = 2'b00; o_rdyE = 2'b00;
    clr_q();
    send(1'b1, hdr(1'b0, 1'b0, 8'h33));
    send(1'b1, hdr(1'b1, 1'b0, 8'h44));
    tick(3);
    chk("t3_held", 72'(q_dat.size()), 72'd0);
    o_rdy = 2'b11; o_rdyE = 2'b11;
    tick(8);
    chk("t3_cnt", 72'(q_dat.size()), 72'd2);
    if (q_dat.size() == 2) begin
      chk("t3_first", q_dat[0], hdr(1'b1, 1'b0, 8'h44));
      chk("t3_second", q_dat[1], hdr(1'b0, 1'b0, 8'h33));
      chk("t3_gap", 72'(q_cyc[1] - q_cyc[0]), 72'd2);
    end

    // 4: long pri0 waits for o_rdy even though o_rdyE is granted
    o_rdy = 2'b00; o_rdyE = 2'b11;
    clr_q();
    send_long(1'b0, 8'h55, 8);
    tick(10);
    chk("t4_block", 72'(q_dat.size()), 72'd0);
    chk("t4_lrdy", 72'(l_rdy), 72'd2);
    o_rdy = 2'b01;
    tick(14);
    chk("t4_cnt", 72'(q_dat.size()), 72'd9);
    chk_long("t4", 0, 1'b0, 8'h55);
    chk("t4_lrdy2", 72'(l_rdy), 72'd3);

    // 5a: payload word with no open packet
    o_rdy = 2'b11; o_rdyE = 2'b11;
    clr_q();
    chk("t5_err0", 72'(ff_err), 72'd0);
    send(1'b0, 72'hDEAD);
    tick(6);
    chk("t5a_err", 72'(ff_err), 72'd1);
    chk("t5a_bus", 72'(q_dat.size()), 72'd0);

    // 5b: second long packet overflows at word 17; only the first packet survives
    rst = 1'b0; tick(1); rst = 1'b1; tick(1);
    chk("t5b_rst_err", 72'(ff_err), 72'd0);
    o_rdy = 2'b00; o_rdyE = 2'b00;
    clr_q();
    send_long(1'b0, 8'h66, 8);
    tick(1);
    chk("t5b_ok", 72'(ff_err), 72'd0);
    send_long(1'b0, 8'h77, 6);
    chk("t5b_16", 72'(ff_err), 72'd0);
    send(1'b0, pay(8'h77, 6));
    chk("t5b_17", 72'(ff_err), 72'd1);
    send(1'b0, pay(8'h77, 7));
    o_rdy = 2'b11; o_rdyE = 2'b11;
    tick(16);
    chk("t5b_cnt", 72'(q_dat.size()), 72'd9);
    chk_long("t5b", 0, 1'b0, 8'h66);
    chk("t5b_sticky", 72'(ff_err), 72'd1);

    // 6: reset while word 4 of a long packet is on the bus
    clr_q();
    send_long(1'b1, 8'h88, 8);
    tick(4);
    chk("t6_w4_stb", 72'(o_stb), 72'd1);
    chk("t6_w4_data", o_data, pay(8'h88, 2));
    rst = 1'b0;
    tick(1);
    chk("t6_stb", 72'(o_stb), 72'd0);
    chk("t6_err", 72'(ff_err), 72'd0);
    chk("t6_lrdy", 72'(l_rdy), 72'd3);
    chk("t6_data", o_data, 72'd0);
    rst = 1'b1;
    clr_q();
    tick(15);
    chk("t6_flushed", 72'(q_dat.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
